// File: rtl/glip_uart_credit_arbiter.sv
// glip_uart_credit_arbiter: per-channel ingress credit ledgers with a
// programmable return threshold; a round-robin arbiter serialises credit
// grant messages onto a single valid/ready port feeding the control framer.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   com_rst             synchronous soft reset (same effect as rst_n)
//   transfer_in         one pulse per word consumed from ingress FIFO c
//   credit_out_valid    credit message offered
//   credit_out_ready    framer accepts the message
//   credit_out_channel  channel of the offered message
//   credit_out_val      credit amount of the offered message
//   host_credit         credit held by the host, channel c at [c*CREDIT_WIDTH +: CREDIT_WIDTH]
//   error               sticky credit-underflow flag
module glip_uart_credit_arbiter #(
  parameter int unsigned CHANNELS       = 2,
  parameter int unsigned CREDIT_WIDTH   = 15,
  parameter int unsigned INITIAL_CREDIT = 1024,
  parameter int unsigned THRESHOLD      = 512,
  localparam int unsigned CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             com_rst,
  input  logic [CHANNELS-1:0]              transfer_in,
  output logic                             credit_out_valid,
  input  logic                             credit_out_ready,
  output logic [CH_W-1:0]                  credit_out_channel,
  output logic [CREDIT_WIDTH-1:0]          credit_out_val,
  output logic [CHANNELS*CREDIT_WIDTH-1:0] host_credit,
  output logic                             error
);

  localparam int unsigned IDX_W = CH_W + 1;
  localparam logic [CREDIT_WIDTH-1:0] INIT_C  = CREDIT_WIDTH'(INITIAL_CREDIT);
  localparam logic [CREDIT_WIDTH-1:0] THR_C   = CREDIT_WIDTH'(THRESHOLD);
  localparam logic [CREDIT_WIDTH-1:0] ONE_C   = CREDIT_WIDTH'(1);
  localparam logic [IDX_W-1:0]        CH_CNT  = IDX_W'(CHANNELS);
  localparam logic [CH_W-1:0]         CH_LAST = CH_W'(CHANNELS - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [CREDIT_WIDTH-1:0] host_q [CHANNELS];
  logic [CREDIT_WIDTH-1:0] host_d [CHANNELS];
  logic [CREDIT_WIDTH-1:0] ret_q  [CHANNELS];
  logic [CREDIT_WIDTH-1:0] ret_d  [CHANNELS];
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [CREDIT_WIDTH-1:0] val_q, val_d;
  logic [CH_W-1:0]         rr_q, rr_d;
  logic                    valid_q, valid_d;
  logic                    error_q, error_d;

  logic                    found;
  logic [CH_W-1:0]         win;
  logic [IDX_W-1:0]        idx;

  // Ledger updates, round-robin pick and message FSM.
  always_comb begin
    state_d = state_q;
    host_d  = host_q;
    ret_d   = ret_q;
    ch_d    = ch_q;
    val_d   = val_q;
    rr_d    = rr_q;
    valid_d = valid_q;
    error_d = error_q;
    found   = 1'b0;
    win     = '0;
    idx     = '0;

    // A consumed word moves one credit from host to returnable; none held is an underflow.
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (transfer_in[c]) begin
        if (host_q[c] != '0) begin
          host_d[c] = host_q[c] - ONE_C;
          ret_d[c]  = ret_q[c] + ONE_C;
        end else begin
          error_d = 1'b1;
        end
      end
    end

    // First eligible channel at or after rr, wrapping.
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      idx = {1'b0, rr_q} + IDX_W'(i);
      if (idx >= CH_CNT) idx = idx - CH_CNT;
      if (!found && (ret_q[idx[CH_W-1:0]] >= THR_C)) begin
        found = 1'b1;
        win   = idx[CH_W-1:0];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (found) begin
          ch_d       = win;
          val_d      = ret_q[win];
          // A same-cycle transfer on the winner lands after the snapshot.
          ret_d[win] = (transfer_in[win] && (host_q[win] != '0)) ? ONE_C : '0;
          valid_d    = 1'b1;
          state_d    = ST_OFFER;
        end
      end
      ST_OFFER: begin
        valid_d = 1'b1;
        if (credit_out_ready) begin
          // host_d already carries any same-cycle decrement.
          host_d[ch_q] = host_d[ch_q] + val_q;
          rr_d         = (ch_q == CH_LAST) ? '0 : ch_q + CH_W'(1);
          valid_d      = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Soft reset wins over everything, including a handshake.
    if (com_rst) begin
      state_d = ST_IDLE;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        host_d[c] = '0;
        ret_d[c]  = INIT_C;
      end
      ch_d    = '0;
      val_d   = '0;
      rr_d    = '0;
      valid_d = 1'b0;
      error_d = 1'b0;
    end
  end

  // State and ledger registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        host_q[c] <= '0;
        ret_q[c]  <= INIT_C;
      end
      ch_q    <= '0;
      val_q   <= '0;
      rr_q    <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      host_q  <= host_d;
      ret_q   <= ret_d;
      ch_q    <= ch_d;
      val_q   <= val_d;
      rr_q    <= rr_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end

  assign credit_out_valid   = valid_q;
  assign credit_out_channel = ch_q;
  assign credit_out_val     = val_q;
  assign error              = error_q;

  // Flatten host ledgers onto the output bus.
  always_comb begin
    host_credit = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      host_credit[c*CREDIT_WIDTH +: CREDIT_WIDTH] = host_q[c];
    end
  end

endmodule

// File: tb/tb_glip_uart_credit_arbiter.sv
// Self-checking bench for glip_uart_credit_arbiter (CHANNELS=2, CREDIT_WIDTH=15,
// INITIAL_CREDIT=1024, THRESHOLD=512). Expected messages are queued when the
// stimulus that causes them is driven and popped at each handshake.
module tb_glip_uart_credit_arbiter;

  localparam int unsigned CH  = 2;
  localparam int unsigned CW  = 15;
  localparam int unsigned CHW = 1;

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic [CW-1:0]  val;
  } msg_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              com_rst;
  logic [CH-1:0]     transfer_in;
  logic              credit_out_valid;
  logic              credit_out_ready;
  logic [CHW-1:0]    credit_out_channel;
  logic [CW-1:0]     credit_out_val;
  logic [CH*CW-1:0]  host_credit;
  logic              error;

  msg_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_hs = -100;

  glip_uart_credit_arbiter #(
    .CHANNELS(CH), .CREDIT_WIDTH(CW), .INITIAL_CREDIT(1024), .THRESHOLD(512)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .com_rst           (com_rst),
    .transfer_in       (transfer_in),
    .credit_out_valid  (credit_out_valid),
    .credit_out_ready  (credit_out_ready),
    .credit_out_channel(credit_out_channel),
    .credit_out_val    (credit_out_val),
    .host_credit       (host_credit),
    .error             (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int hc(input int c);
    return int'(host_credit[c*CW +: CW]);
  endfunction

  // Scoreboard monitor: pops at every accepted message, also checks the credit bound and spacing.
  always @(negedge clk) begin
    if (rst_n && !com_rst) begin
      int s;
      bit bad;
      bad = 1'b0;
      for (int c = 0; c < CH; c++) begin
        s = hc(c) + ((credit_out_valid && int'(credit_out_channel) == c) ? int'(credit_out_val) : 0);
        if (s > 1024) bad = 1'b1;
      end
      n_tests++;
      if (bad) begin
        n_fail++;
        $display("FAIL credit_bound: host0=%0d host1=%0d inflight=%0d on ch%0d, required sum <= 1024",
                 hc(0), hc(1), credit_out_valid ? credit_out_val : '0, credit_out_channel);
      end
      if (credit_out_valid && credit_out_ready) begin
        msg_t m;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_msg: got ch%0d val=%0d, required no message",
                   credit_out_channel, credit_out_val);
        end else begin
          m = exp_q.pop_front();
          if (m !== {credit_out_channel, credit_out_val}) begin
            n_fail++;
            $display("FAIL msg_content: got ch%0d val=%0d, required ch%0d val=%0d",
                     credit_out_channel, credit_out_val, m.ch, m.val);
          end
        end
        n_tests++;
        if (cyc - last_hs < 2) begin
          n_fail++;
          $display("FAIL msg_spacing: got %0d cycles, required >= 2", cyc - last_hs);
        end
        last_hs = cyc;
      end
    end
  end

  task automatic xfer(input logic [CH-1:0] m, input int n);
    @(posedge clk); #1;
    transfer_in = m;
    repeat (n) begin @(posedge clk); #1; end
    transfer_in = '0;
  endtask

  task automatic wait_valid(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (credit_out_valid) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: valid=0 after 20 cycles, required 1", name);
    end
  endtask

  task automatic drain(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !credit_out_valid) done = 1'b1;
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s: %0d messages outstanding valid=%0d, required 0 outstanding",
               name, exp_q.size(), credit_out_valid);
    end
    exp_q.delete();
  endtask

  task automatic quiet(input string name, input int n);
    bit seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (credit_out_valid) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL %s: valid=1, required 0", name);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; com_rst = 1'b0; credit_out_ready = 1'b1; transfer_in = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (credit_out_valid !== 1'b0 || credit_out_channel !== '0 || credit_out_val !== '0) begin
      n_fail++;
      $display("FAIL t1_reset_out: got v=%0d ch=%0d val=%0d, required 0/0/0",
               credit_out_valid, credit_out_channel, credit_out_val);
    end
    n_tests++;
    if (host_credit !== '0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_reset_state: got host=%0d/%0d err=%0d, required 0/0/0", hc(0), hc(1), error);
    end
    exp_q.push_back({1'b0, 15'd1024});
    exp_q.push_back({1'b1, 15'd1024});
    @(posedge clk); #1 rst_n = 1'b1;
    drain("t1_drain", 50);
    quiet("t1_quiet", 10);
    n_tests++;
    if (hc(0) != 1024 || hc(1) != 1024 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_host: got %0d/%0d err=%0d, required 1024/1024 err=0", hc(0), hc(1), error);
    end
  endtask

  task automatic test_threshold();
    xfer(2'b01, 511);
    quiet("t2_below_thr", 5);
    exp_q.push_back({1'b0, 15'd512});
    xfer(2'b01, 1);
    @(negedge clk);
    n_tests++;
    if (credit_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL t2_latency0: got valid=%0d, required 0", credit_out_valid);
    end
    @(negedge clk);
    n_tests++;
    if (credit_out_valid !== 1'b1 || credit_out_channel !== 1'b0 || credit_out_val !== 15'd512) begin
      n_fail++;
      $display("FAIL t2_latency1: got v=%0d ch%0d val=%0d, required v=1 ch0 val=512",
               credit_out_valid, credit_out_channel, credit_out_val);
    end
    drain("t2_drain", 20);
    n_tests++;
    if (hc(0) != 1024) begin
      n_fail++;
      $display("FAIL t2_host0: got %0d, required 1024", hc(0));
    end
  endtask

  task automatic test_backpressure();
    int bad;
    credit_out_ready = 1'b0;
    xfer(2'b01, 512);
    exp_q.push_back({1'b0, 15'd512});
    wait_valid("t3_offer");
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1 transfer_in = 2'b01;
      @(negedge clk);
      if (credit_out_valid !== 1'b1 || credit_out_channel !== 1'b0 || credit_out_val !== 15'd512) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL t3_hold: got %0d unstable cycles (last ch%0d val=%0d), required 0 (ch0 val=512)",
               bad, credit_out_channel, credit_out_val);
    end
    @(posedge clk); #1;
    transfer_in = '0;
    credit_out_ready = 1'b1;
    drain("t3_drain", 20);
    n_tests++;
    if (hc(0) != 924 || hc(1) != 1024) begin
      n_fail++;
      $display("FAIL t3_host: got %0d/%0d, required 924/1024", hc(0), hc(1));
    end
    quiet("t3_no_new_msg", 20);
  endtask

  task automatic test_round_robin();
    // rr=1 after the last ch0 grant: ch1 wins the tie.
    xfer(2'b10, 100);
    exp_q.push_back({1'b1, 15'd512});
    exp_q.push_back({1'b0, 15'd512});
    xfer(2'b11, 412);
    drain("t4_rr1_drain", 30);
    n_tests++;
    if (hc(0) != 1024 || hc(1) != 1024) begin
      n_fail++;
      $display("FAIL t4_rr1_host: got %0d/%0d, required 1024/1024", hc(0), hc(1));
    end
    // A lone ch1 grant moves rr to 0.
    exp_q.push_back({1'b1, 15'd512});
    xfer(2'b10, 512);
    drain("t4_ch1_drain", 30);
    exp_q.push_back({1'b0, 15'd512});
    exp_q.push_back({1'b1, 15'd512});
    xfer(2'b11, 512);
    drain("t4_rr0_drain", 30);
    n_tests++;
    if (hc(0) != 1024 || hc(1) != 1024) begin
      n_fail++;
      $display("FAIL t4_rr0_host: got %0d/%0d, required 1024/1024", hc(0), hc(1));
    end
  endtask

  task automatic test_underflow();
    credit_out_ready = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    transfer_in = 2'b10;
    @(posedge clk); #1 transfer_in = '0;
    @(negedge clk);
    n_tests++;
    if (error !== 1'b1 || hc(0) != 0 || hc(1) != 0) begin
      n_fail++;
      $display("FAIL t5_underflow: got err=%0d host=%0d/%0d, required err=1 host=0/0", error, hc(0), hc(1));
    end
    n_tests++;
    if (credit_out_valid !== 1'b1 || credit_out_channel !== 1'b0 || credit_out_val !== 15'd1024) begin
      n_fail++;
      $display("FAIL t5_offer: got v=%0d ch%0d val=%0d, required v=1 ch0 val=1024",
               credit_out_valid, credit_out_channel, credit_out_val);
    end
    repeat (5) @(negedge clk);
    exp_q.push_back({1'b0, 15'd1024});
    exp_q.push_back({1'b1, 15'd1024});
    @(posedge clk); #1 credit_out_ready = 1'b1;
    drain("t5_drain", 30);
    n_tests++;
    if (error !== 1'b1 || hc(0) != 1024 || hc(1) != 1024) begin
      n_fail++;
      $display("FAIL t5_sticky: got err=%0d host=%0d/%0d, required err=1 host=1024/1024", error, hc(0), hc(1));
    end
    credit_out_ready = 1'b0;
    @(posedge clk); #1 com_rst = 1'b1;
    @(posedge clk); #1 com_rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (error !== 1'b0 || host_credit !== '0 || credit_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_com_rst: got err=%0d host=%0d/%0d v=%0d, required 0 0/0 0",
               error, hc(0), hc(1), credit_out_valid);
    end
    // com_rst coinciding with a handshake drops the message.
    wait_valid("t5_reoffer");
    @(posedge clk); #1;
    com_rst = 1'b1;
    credit_out_ready = 1'b1;
    @(posedge clk); #1;
    com_rst = 1'b0;
    credit_out_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (hc(0) != 0 || credit_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_com_rst_hs: got host0=%0d v=%0d, required 0 0", hc(0), credit_out_valid);
    end
    exp_q.push_back({1'b0, 15'd1024});
    exp_q.push_back({1'b1, 15'd1024});
    @(posedge clk); #1 credit_out_ready = 1'b1;
    drain("t5_regrant", 30);
    n_tests++;
    if (error !== 1'b0 || hc(0) != 1024 || hc(1) != 1024) begin
      n_fail++;
      $display("FAIL t5_regrant_host: got err=%0d host=%0d/%0d, required 0 1024/1024", error, hc(0), hc(1));
    end
  endtask

  task automatic test_async_reset();
    credit_out_ready = 1'b0;
    xfer(2'b01, 512);
    wait_valid("t6_offer");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (credit_out_valid !== 1'b0 || credit_out_channel !== '0 || credit_out_val !== '0 ||
        host_credit !== '0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_async: got v=%0d ch%0d val=%0d host=%0d/%0d err=%0d, required all 0",
               credit_out_valid, credit_out_channel, credit_out_val, hc(0), hc(1), error);
    end
    exp_q.push_back({1'b0, 15'd1024});
    exp_q.push_back({1'b1, 15'd1024});
    @(posedge clk); #1;
    rst_n = 1'b1;
    credit_out_ready = 1'b1;
    drain("t6_drain", 30);
    n_tests++;
    if (hc(0) != 1024 || hc(1) != 1024 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_host: got %0d/%0d err=%0d, required 1024/1024 err=0", hc(0), hc(1), error);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_threshold();
    test_backpressure();
    test_round_robin();
    test_underflow();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
